nand_read_scheduler: RTL and testbench

- Round-robin scheduler that shares one NAND read_operation controller among NREQ requesters.
- Each requester presents a page address and a byte length. The scheduler latches the winner's command, pulses the read start, drives address and length into the controller, and waits for complete.
- It returns a per-requester done or error pulse.
- It sits between the host-side request logic and read_operation, and owns RS/DA/RL.

---
 rtl/nand_read_scheduler.sv | 118 +++++++++++
 tb/tb_nand_read_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/nand_read_scheduler.sv
// Round-robin arbiter sharing one NAND read_operation controller among NREQ requesters.
// The winner's address/length are latched on the grant edge, then one read is issued and supervised.
module nand_read_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   addr_in,
    input  logic [8*NREQ-1:0]    len_in,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic                 rs_out,
    output logic [15:0]          da_out,
    output logic [7:0]           rl_out,
    input  logic                 is_ready_in,
    input  logic                 complete_in,
    output logic                 busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {IDLE, ZERO, ISSUE, WAIT, COOL} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [TO_W-1:0] cnt;

    logic            found;
    logic [PW-1:0]   win;
    logic [15:0]     win_addr;
    logic [7:0]      win_len;
    int              idx;

    // Search ptr, ptr+1, ... wrapping; the first requester found wins.
    always_comb begin
        found    = 1'b0;
        win      = ptr;
        win_addr = '0;
        win_len  = '0;
        idx      = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                win      = PW'(idx);
                win_addr = addr_in[16*idx +: 16];
                win_len  = len_in[8*idx +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            grant  <= '0;
            done   <= '0;
            err    <= '0;
            rs_out <= 1'b0;
            da_out <= '0;
            rl_out <= '0;
            busy   <= 1'b0;
        end else begin
            done   <= '0;
            err    <= '0;
            rs_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (is_ready_in && !complete_in && found) begin
                        da_out <= win_addr;
                        rl_out <= win_len;
                        grant  <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                        ptr    <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
                        busy   <= 1'b1;
                        state  <= (win_len == 8'd0) ? ZERO : ISSUE;
                    end
                end
                // Zero-length reads are acknowledged without touching the controller.
                ZERO: begin
                    done  <= grant;
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                ISSUE: begin
                    rs_out <= 1'b1;
                    cnt    <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (complete_in) begin
                        done  <= grant;
                        grant <= '0;
                        state <= COOL;
                    end else if (cnt == TO_W'(TIMEOUT-1)) begin
                        err   <= grant;
                        grant <= '0;
                        state <= COOL;
                    end
                end
                // Hold off until the controller has dropped the previous completion.
                COOL: begin
                    if (!complete_in && is_ready_in) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nand_read_scheduler.sv
// Directed bench for nand_read_scheduler: table of full read operations plus corner-case sequences.
module tb_nand_read_scheduler;
    localparam int NREQ = 4;
    localparam int TOUT = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [16*NREQ-1:0] addr_in;
    logic [8*NREQ-1:0] len_in;
    logic [NREQ-1:0]   grant, done, err;
    logic              rs_out, busy;
    logic [15:0]       da_out;
    logic [7:0]        rl_out;
    logic              is_ready_in, complete_in;

    int n_vec = 0;
    int n_err = 0;

    nand_read_scheduler #(.NREQ(NREQ), .TIMEOUT(TOUT), .TO_W(5)) dut (
        .clk(clk), .reset(reset), .req(req), .addr_in(addr_in), .len_in(len_in),
        .grant(grant), .done(done), .err(err), .rs_out(rs_out), .da_out(da_out),
        .rl_out(rl_out), .is_ready_in(is_ready_in), .complete_in(complete_in), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  exp_grant;
        logic [15:0] exp_da;
        logic [7:0]  exp_rl;
        int          cdly;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One complete read: grant, rs_out two edges after req, complete after cdly cycles.
    task automatic run_op(input vec_t v);
        @(negedge clk); req = v.req;
        @(negedge clk);
        chk("grant", 32'(grant), 32'(v.exp_grant));
        chk("busy_on", 32'(busy), 32'd1);
        chk("rs_early", 32'(rs_out), 32'd0);
        @(negedge clk);
        chk("rs_pulse", 32'(rs_out), 32'd1);
        chk("da_out", 32'(da_out), 32'(v.exp_da));
        chk("rl_out", 32'(rl_out), 32'(v.exp_rl));
        @(negedge clk);
        chk("rs_off", 32'(rs_out), 32'd0);
        repeat (v.cdly) @(negedge clk);
        complete_in = 1'b1;
        @(negedge clk);
        chk("done", 32'(done), 32'(v.exp_grant));
        chk("no_err", 32'(err), 32'd0);
        chk("grant_clr", 32'(grant), 32'd0);
        complete_in = 1'b0;
        req = '0;
        @(negedge clk);
        chk("busy_off", 32'(busy), 32'd0);
        chk("done_1cyc", 32'(done), 32'd0);
    endtask

    initial begin
        vecs[0] = '{4'b0001, 4'b0001, 16'h000F, 8'd8,  12};
        vecs[1] = '{4'b1111, 4'b0010, 16'h2222, 8'd20, 5};
        vecs[2] = '{4'b1111, 4'b0100, 16'h3333, 8'd30, 5};
        vecs[3] = '{4'b1111, 4'b1000, 16'h4444, 8'd40, 5};
        vecs[4] = '{4'b1111, 4'b0001, 16'h000F, 8'd8,  5};
        vecs[5] = '{4'b1001, 4'b1000, 16'h4444, 8'd40, 0};
        vecs[6] = '{4'b0110, 4'b0010, 16'h2222, 8'd20, 3};
        vecs[7] = '{4'b0011, 4'b0001, 16'h000F, 8'd8,  1};

        reset = 1'b1; req = '0; complete_in = 1'b0; is_ready_in = 1'b1;
        addr_in = {16'h4444, 16'h3333, 16'h2222, 16'h000F};
        len_in  = {8'd40, 8'd30, 8'd20, 8'd8};
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rs", 32'(rs_out), 32'd0);
        chk("rst_da", 32'(da_out), 32'd0);
        chk("rst_rl", 32'(rl_out), 32'd0);
        chk("rst_done_err", 32'({done, err}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // Zero length, ptr=1: requester 2 wins, done without rs_out.
        len_in[23:16] = 8'd0;
        @(negedge clk); req = 4'b0100;
        @(negedge clk);
        chk("z_grant", 32'(grant), 32'b0100);
        chk("z_rs0", 32'(rs_out), 32'd0);
        chk("z_done_early", 32'(done), 32'd0);
        @(negedge clk);
        chk("z_done", 32'(done), 32'b0100);
        chk("z_grant_clr", 32'(grant), 32'd0);
        chk("z_rs1", 32'(rs_out), 32'd0);
        chk("z_busy", 32'(busy), 32'd0);
        req = '0;
        @(negedge clk);
        chk("z_rs2", 32'(rs_out), 32'd0);
        chk("z_done_off", 32'(done), 32'd0);
        len_in[23:16] = 8'd30;

        // Timeout, ptr=3: err exactly TOUT cycles after the rs_out cycle, then COOL until ready.
        @(negedge clk); req = 4'b1000;
        @(negedge clk);
        chk("t_grant", 32'(grant), 32'b1000);
        @(negedge clk);
        chk("t_rs", 32'(rs_out), 32'd1);
        is_ready_in = 1'b0;
        for (int k = 1; k < TOUT; k++) begin
            @(negedge clk);
            if (err !== 4'b0 || grant !== 4'b1000) begin
                n_err++;
                $display("FAIL t_wait k=%0d: err=%b grant=%b, expected err=0000 grant=1000", k, err, grant);
            end
        end
        n_vec++;
        @(negedge clk);
        chk("t_err", 32'(err), 32'b1000);
        chk("t_no_done", 32'(done), 32'd0);
        chk("t_grant_clr", 32'(grant), 32'd0);
        req = '0;
        repeat (3) @(negedge clk);
        chk("t_cool_busy", 32'(busy), 32'd1);
        chk("t_err_1cyc", 32'(err), 32'd0);
        is_ready_in = 1'b1;
        @(negedge clk);
        chk("t_idle", 32'(busy), 32'd0);

        // Collision, ptr=0: complete_in on the cycle counter hits TOUT-1.
        @(negedge clk); req = 4'b0001;
        @(negedge clk);
        chk("c_grant", 32'(grant), 32'b0001);
        @(negedge clk);
        chk("c_rs", 32'(rs_out), 32'd1);
        repeat (TOUT-1) @(negedge clk);
        chk("c_pre_err", 32'(err), 32'd0);
        complete_in = 1'b1;
        @(negedge clk);
        chk("c_done", 32'(done), 32'b0001);
        chk("c_no_err", 32'(err), 32'd0);
        complete_in = 1'b0; req = '0;
        @(negedge clk);
        chk("c_no_err2", 32'(err), 32'd0);
        chk("c_busy", 32'(busy), 32'd0);

        // Reset during WAIT, ptr=1: requester 2 owns, then reset.
        @(negedge clk); req = 4'b0100;
        @(negedge clk);
        chk("r_grant", 32'(grant), 32'b0100);
        @(negedge clk);
        chk("r_rs", 32'(rs_out), 32'd1);
        reset = 1'b1;
        #1;
        chk("r_async_grant", 32'(grant), 32'd0);
        chk("r_async_rs", 32'(rs_out), 32'd0);
        chk("r_async_busy", 32'(busy), 32'd0);
        req = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("r_no_done_err", 32'({done, err}), 32'd0);
        end
        // ptr must be back at 0: 1010 picks requester 1 (ptr=3 would pick 3).
        run_op('{4'b1010, 4'b0010, 16'h2222, 8'd20, 2});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
        $fatal(1, "watchdog");
    end
endmodule
